// File: rtl/bus_pkg.sv
// Shared constants, register codes, FSM states and width helpers for the bus transfer sequencer.
package bus_pkg;

    localparam int unsigned BUS_W  = 24;
    localparam int unsigned N_REG  = 16;
    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] PC   = 4'd0;
    localparam logic [CODE_W-1:0] IR   = 4'd1;
    localparam logic [CODE_W-1:0] AR   = 4'd2;
    localparam logic [CODE_W-1:0] AC   = 4'd3;
    localparam logic [CODE_W-1:0] X    = 4'd4;
    localparam logic [CODE_W-1:0] Y    = 4'd5;
    localparam logic [CODE_W-1:0] Z    = 4'd6;
    localparam logic [CODE_W-1:0] STXY = 4'd7;
    localparam logic [CODE_W-1:0] STYZ = 4'd8;
    localparam logic [CODE_W-1:0] STXZ = 4'd9;
    localparam logic [CODE_W-1:0] R    = 4'd10;
    localparam logic [CODE_W-1:0] R1   = 4'd11;
    localparam logic [CODE_W-1:0] R2   = 4'd12;
    localparam logic [CODE_W-1:0] R3   = 4'd13;
    localparam logic [CODE_W-1:0] DM   = 4'd14;
    localparam logic [CODE_W-1:0] IM   = 4'd15;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StDrive,
        StCapture,
        StWrite
    } state_e;

    function automatic int unsigned reg_width(input logic [CODE_W-1:0] code);
        case (code)
            X, Y, Z, R1, DM: return 8;
            AC, R2:          return 24;
            default:         return 16;
        endcase
    endfunction

    function automatic logic [BUS_W-1:0] width_mask(input logic [CODE_W-1:0] code);
        case (reg_width(code))
            8:       return 24'h0000FF;
            16:      return 24'h00FFFF;
            default: return 24'hFFFFFF;
        endcase
    endfunction

endpackage

// File: rtl/bus_req_fifo.sv
// Two-entry request buffer holding {src, dst} code pairs; pointers carry a wrap bit.
module bus_req_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [7:0] mem_q [2];
    logic [1:0] wptr_q;
    logic [1:0] rptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= 2'd0;
            rptr_q   <= 2'd0;
            mem_q[0] <= 8'd0;
            mem_q[1] <= 8'd0;
        end else begin
            if (push_i && !full_o) begin
                mem_q[wptr_q[0]] <= data_i;
                wptr_q           <= wptr_q + 2'd1;
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + 2'd1;
            end
        end
    end

    // Same slot index with differing wrap bits means the writer has lapped the reader.
    assign full_o  = (wptr_q[0] == rptr_q[0]) && (wptr_q[1] != rptr_q[1]);
    assign empty_o = (wptr_q == rptr_q);
    assign data_o  = mem_q[rptr_q[0]];

endmodule

// File: rtl/bus_xfer_seq.sv
// Sequences register-to-register moves over the shared bus: check, drive source, capture, write.
module bus_xfer_seq
    import bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_src,
    input  logic [3:0]       req_dst,
    input  logic [BUS_W-1:0] busin,
    output logic             read_en,
    output logic [N_REG-1:0] src_sel,
    output logic [N_REG-1:0] dst_we,
    output logic [BUS_W-1:0] wdata,
    output logic             done,
    output logic             err,
    output logic [15:0]      xfer_cnt
);

    state_e           state_q;
    logic [3:0]       cur_src_q;
    logic [3:0]       cur_dst_q;
    logic [BUS_W-1:0] cap_q;
    logic [15:0]      xfer_cnt_q;
    logic             read_en_q;
    logic [N_REG-1:0] src_sel_q;
    logic [N_REG-1:0] dst_we_q;
    logic             done_q;
    logic             err_q;

    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic [7:0] head;

    function automatic logic is_illegal(input logic [3:0] src, input logic [3:0] dst);
        return (src == dst) || (dst == IM);
    endfunction

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == StIdle) && !fifo_empty;

    bus_req_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({req_src, req_dst}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Strobes are set on the edge entering their state so they are plain register outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_src_q  <= 4'd0;
            cur_dst_q  <= 4'd0;
            cap_q      <= '0;
            xfer_cnt_q <= 16'd0;
            read_en_q  <= 1'b0;
            src_sel_q  <= '0;
            dst_we_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        cur_src_q <= head[7:4];
                        cur_dst_q <= head[3:0];
                        err_q     <= is_illegal(head[7:4], head[3:0]);
                        state_q   <= StCheck;
                    end
                end
                StCheck: begin
                    if (is_illegal(cur_src_q, cur_dst_q)) begin
                        state_q <= StIdle;
                    end else begin
                        read_en_q <= 1'b1;
                        src_sel_q <= N_REG'(1) << cur_src_q;
                        state_q   <= StDrive;
                    end
                end
                StDrive: begin
                    state_q <= StCapture;
                end
                StCapture: begin
                    cap_q      <= busin & width_mask(cur_src_q);
                    read_en_q  <= 1'b0;
                    src_sel_q  <= '0;
                    dst_we_q   <= N_REG'(1) << cur_dst_q;
                    done_q     <= 1'b1;
                    xfer_cnt_q <= xfer_cnt_q + 16'd1;
                    state_q    <= StWrite;
                end
                StWrite: begin
                    dst_we_q <= '0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign read_en  = read_en_q;
    assign src_sel  = src_sel_q;
    assign dst_we   = dst_we_q;
    assign done     = done_q;
    assign err      = err_q;
    assign xfer_cnt = xfer_cnt_q;
    assign wdata    = (state_q == StWrite) ? (cap_q & width_mask(cur_dst_q)) : '0;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed bench for bus_xfer_seq: vector table plus FIFO-full, mid-transfer reset and counter wrap.
module tb_bus_xfer_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_src;
    logic [3:0]  req_dst;
    logic [23:0] busin;
    logic        read_en;
    logic [15:0] src_sel;
    logic [15:0] dst_we;
    logic [23:0] wdata;
    logic        done;
    logic        err;
    logic [15:0] xfer_cnt;

    bus_xfer_seq dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .busin     (busin),
        .read_en   (read_en),
        .src_sel   (src_sel),
        .dst_we    (dst_we),
        .wdata     (wdata),
        .done      (done),
        .err       (err),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [23:0] bus;
        logic        exp_err;
        logic [15:0] exp_sel;
        logic [15:0] exp_we;
        logic [23:0] exp_wdata;
    } vec_t;

    vec_t        vecs [7];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] exp_cnt = 16'd0;
    int          cyc = 0;
    int          overlap = 0;
    int          done_cyc [$];
    logic [15:0] done_we [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cyc.push_back(cyc);
            done_we.push_back(dst_we);
        end
        if ((src_sel != 16'd0) && (dst_we != 16'd0)) overlap++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Issues one request into an idle, empty sequencer and checks each cycle through WRITE.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        req_valid = 1'b1;
        req_src   = v.src;
        req_dst   = v.dst;
        busin     = v.bus;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".idle_err"}, 32'(err), 32'd0);
        @(negedge clk);
        chk({tag, ".check_err"}, 32'(err), 32'(v.exp_err));
        chk({tag, ".check_rd"}, 32'(read_en), 32'd0);
        if (v.exp_err) begin
            @(negedge clk);
            chk({tag, ".post_err"}, 32'(err), 32'd0);
            chk({tag, ".post_rd"}, 32'(read_en), 32'd0);
            chk({tag, ".cnt"}, 32'(xfer_cnt), 32'(exp_cnt));
        end else begin
            @(negedge clk);
            chk({tag, ".drive_rd"}, 32'(read_en), 32'd1);
            chk({tag, ".drive_sel"}, 32'(src_sel), 32'(v.exp_sel));
            @(negedge clk);
            chk({tag, ".cap_sel"}, 32'(src_sel), 32'(v.exp_sel));
            chk({tag, ".cap_we"}, 32'(dst_we), 32'd0);
            @(negedge clk);
            exp_cnt = exp_cnt + 16'd1;
            chk({tag, ".wr_we"}, 32'(dst_we), 32'(v.exp_we));
            chk({tag, ".wr_data"}, 32'(wdata), 32'(v.exp_wdata));
            chk({tag, ".wr_done"}, 32'(done), 32'd1);
            chk({tag, ".wr_sel"}, 32'(src_sel), 32'd0);
            chk({tag, ".wr_cnt"}, 32'(xfer_cnt), 32'(exp_cnt));
            @(negedge clk);
            chk({tag, ".after_done"}, 32'(done), 32'd0);
            chk({tag, ".after_we"}, 32'(dst_we), 32'd0);
            chk({tag, ".after_data"}, 32'(wdata), 32'd0);
        end
    endtask

    initial begin
        int waits;
        int k;
        logic bad;

        vecs[0] = '{4'd3,  4'd4,  24'hABCDEF, 1'b0, 16'h0008, 16'h0010, 24'h0000EF};
        vecs[1] = '{4'd11, 4'd12, 24'hFFFF5A, 1'b0, 16'h0800, 16'h1000, 24'h00005A};
        vecs[2] = '{4'd5,  4'd5,  24'h123456, 1'b1, 16'h0000, 16'h0000, 24'h000000};
        vecs[3] = '{4'd0,  4'd15, 24'h123456, 1'b1, 16'h0000, 16'h0000, 24'h000000};
        vecs[4] = '{4'd0,  4'd3,  24'h123456, 1'b0, 16'h0001, 16'h0008, 24'h003456};
        vecs[5] = '{4'd12, 4'd1,  24'h89ABCD, 1'b0, 16'h1000, 16'h0002, 24'h00ABCD};
        vecs[6] = '{4'd15, 4'd14, 24'h00FEDC, 1'b0, 16'h8000, 16'h4000, 24'h0000DC};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_src   = 4'd0;
        req_dst   = 4'd0;
        busin     = 24'd0;
        repeat (2) @(negedge clk);
        chk("rst.read_en", 32'(read_en), 32'd0);
        chk("rst.src_sel", 32'(src_sel), 32'd0);
        chk("rst.dst_we", 32'(dst_we), 32'd0);
        chk("rst.wdata", 32'(wdata), 32'd0);
        chk("rst.done_err", 32'({done, err}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle.ready", 32'(req_ready), 32'd1);
        chk("idle.cnt", 32'(xfer_cnt), 32'd0);
        chk("idle.strobes", 32'({read_en, done, err, |src_sel, |dst_we}), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Four requests with valid held: the fourth waits for the second pop.
        done_cyc.delete();
        done_we.delete();
        @(negedge clk);
        k = cyc;
        req_valid = 1'b1;
        busin     = 24'h00C0DE;
        req_src = 4'd0; req_dst = 4'd2;
        chk("fifo.ready0", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_src = 4'd1; req_dst = 4'd3;
        chk("fifo.ready1", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_src = 4'd2; req_dst = 4'd4;
        chk("fifo.ready2", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_src = 4'd3; req_dst = 4'd5;
        chk("fifo.full", 32'(req_ready), 32'd0);
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("fifo.wait_cycles", 32'(waits), 32'd4);
        @(negedge clk);
        req_valid = 1'b0;
        waits = 0;
        while (done_cyc.size() < 4 && waits < 60) begin
            @(negedge clk);
            waits++;
        end
        chk("fifo.ndone", 32'(done_cyc.size()), 32'd4);
        if (done_cyc.size() == 4) begin
            chk("fifo.latency", 32'(done_cyc[0] - k), 32'd5);
            chk("fifo.gap1", 32'(done_cyc[1] - done_cyc[0]), 32'd5);
            chk("fifo.gap2", 32'(done_cyc[2] - done_cyc[1]), 32'd5);
            chk("fifo.gap3", 32'(done_cyc[3] - done_cyc[2]), 32'd5);
            chk("fifo.we0", 32'(done_we[0]), 32'h0004);
            chk("fifo.we1", 32'(done_we[1]), 32'h0008);
            chk("fifo.we2", 32'(done_we[2]), 32'h0010);
            chk("fifo.we3", 32'(done_we[3]), 32'h0020);
        end
        exp_cnt = exp_cnt + 16'd4;
        @(negedge clk);
        chk("fifo.cnt", 32'(xfer_cnt), 32'(exp_cnt));

        // Reset asserted while the source is being driven aborts the move.
        @(negedge clk);
        req_valid = 1'b1; req_src = 4'd3; req_dst = 4'd4; busin = 24'h777777;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst.drive_rd", 32'(read_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst.rd", 32'(read_en), 32'd0);
        chk("mrst.sel", 32'(src_sel), 32'd0);
        chk("mrst.cnt", 32'(xfer_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 16'd0;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (dst_we != 16'd0 || done || read_en) bad = 1'b1;
        end
        chk("mrst.no_write", 32'(bad), 32'd0);
        chk("mrst.ready", 32'(req_ready), 32'd1);

        // Counter wrap: preload the count register and complete one move.
        @(negedge clk);
        force dut.xfer_cnt_q = 16'hFFFF;
        #1;
        release dut.xfer_cnt_q;
        exp_cnt = 16'hFFFF;
        run_vec(vecs[0], "wrap");

        chk("overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
